// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: load-use stalls, redirect flushes,
// a fixed-latency mult/div freeze, and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             ID_md,
    input  logic [4:0]       EX_dst,
    input  logic             EX_MemtoReg,
    input  logic             EX_RegWrite,
    input  logic             EX_redirect,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [15:0]      flush_count,
    output logic             state_dbg
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] MD_INIT = 8'(MD_LAT - 1);

    state_t           state_q, state_d;
    logic [7:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [15:0]      flush_q, flush_d;

    logic lu;
    logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_stall_c, idex_bubble_c;
    logic md_busy_c, md_done_c;

    assign lu = EX_MemtoReg && EX_RegWrite && (EX_dst != 5'd0) &&
                ((ID_uses_rs && (ID_rs == EX_dst)) || (ID_uses_rt && (ID_rt == EX_dst)));

    // Controls are a function of state and inputs; the reset term forces them low asynchronously.
    always_comb begin
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_stall_c  = 1'b0;
        idex_bubble_c = 1'b0;
        md_busy_c     = 1'b0;
        md_done_c     = 1'b0;
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        if (rst) begin
            case (state_q)
                RUN: begin
                    if (EX_redirect) begin
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                    end else if (lu) begin
                        pc_stall_c    = 1'b1;
                        ifid_stall_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                    end else if (ID_md) begin
                        state_d  = MD_BUSY;
                        md_cnt_d = MD_INIT;
                    end
                end
                MD_BUSY: begin
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_stall_c = 1'b1;
                    md_busy_c    = 1'b1;
                    if (md_cnt_q == 8'd0) begin
                        md_done_c = 1'b1;
                        state_d   = RUN;
                    end else begin
                        md_cnt_d = md_cnt_q - 8'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (pc_stall_c && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
        if (ifid_flush_c && !(&flush_q)) flush_d = flush_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            md_cnt_q <= 8'd0;
            stall_q  <= '0;
            flush_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign pc_stall     = pc_stall_c;
    assign ifid_stall   = ifid_stall_c;
    assign ifid_flush   = ifid_flush_c;
    // Bubble beats hold so ID/EX never sees both.
    assign idex_stall   = idex_stall_c & ~idex_bubble_c;
    assign idex_bubble  = idex_bubble_c;
    assign md_busy      = md_busy_c;
    assign md_done      = md_done_c;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: instance 0 uses MD_LAT=4/CNT_W=32, instance 1 uses MD_LAT=3/CNT_W=4.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] id_rs [2];
    logic [4:0] id_rt [2];
    logic       urs [2];
    logic       urt [2];
    logic       id_md [2];
    logic [4:0] ex_dst [2];
    logic       ex_mtr [2];
    logic       ex_rw [2];
    logic       ex_redir [2];
    logic       rst_n [2];

    logic pc_st [2];
    logic ifid_st [2];
    logic ifid_fl [2];
    logic idex_st [2];
    logic idex_bub [2];
    logic busy [2];
    logic done [2];
    logic st_dbg [2];
    logic [31:0] stall_a;
    logic [3:0]  stall_b;
    logic [15:0] flush_a;
    logic [15:0] flush_b;

    int n_tests = 0;
    int n_fail  = 0;

    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, md_busy, md_done}
    localparam logic [6:0] C_0   = 7'b0000000;
    localparam logic [6:0] C_LU  = 7'b1100100;
    localparam logic [6:0] C_RD  = 7'b0010100;
    localparam logic [6:0] C_MD  = 7'b1101010;
    localparam logic [6:0] C_MDD = 7'b1101011;

    pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst_n[0]),
        .ID_rs(id_rs[0]), .ID_rt(id_rt[0]), .ID_uses_rs(urs[0]), .ID_uses_rt(urt[0]),
        .ID_md(id_md[0]), .EX_dst(ex_dst[0]), .EX_MemtoReg(ex_mtr[0]), .EX_RegWrite(ex_rw[0]),
        .EX_redirect(ex_redir[0]),
        .pc_stall(pc_st[0]), .ifid_stall(ifid_st[0]), .ifid_flush(ifid_fl[0]),
        .idex_stall(idex_st[0]), .idex_bubble(idex_bub[0]), .md_busy(busy[0]), .md_done(done[0]),
        .stall_cycles(stall_a), .flush_count(flush_a), .state_dbg(st_dbg[0])
    );

    pipe_hazard_ctrl #(.MD_LAT(3), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst_n[1]),
        .ID_rs(id_rs[1]), .ID_rt(id_rt[1]), .ID_uses_rs(urs[1]), .ID_uses_rt(urt[1]),
        .ID_md(id_md[1]), .EX_dst(ex_dst[1]), .EX_MemtoReg(ex_mtr[1]), .EX_RegWrite(ex_rw[1]),
        .EX_redirect(ex_redir[1]),
        .pc_stall(pc_st[1]), .ifid_stall(ifid_st[1]), .ifid_flush(ifid_fl[1]),
        .idex_stall(idex_st[1]), .idex_bubble(idex_bub[1]), .md_busy(busy[1]), .md_done(done[1]),
        .stall_cycles(stall_b), .flush_count(flush_b), .state_dbg(st_dbg[1])
    );

    function automatic logic [6:0] ctrl(int k);
        return {pc_st[k], ifid_st[k], ifid_fl[k], idex_st[k], idex_bub[k], busy[k], done[k]};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(int k, logic [4:0] rs, logic [4:0] rt, logic u_rs, logic u_rt,
                         logic md, logic [4:0] dst, logic mtr, logic rw, logic redir);
        id_rs[k]    = rs;
        id_rt[k]    = rt;
        urs[k]      = u_rs;
        urt[k]      = u_rt;
        id_md[k]    = md;
        ex_dst[k]   = dst;
        ex_mtr[k]   = mtr;
        ex_rw[k]    = rw;
        ex_redir[k] = redir;
    endtask

    task automatic idle(int k);
        drive(k, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset with a redirect and a load-use condition present: controls must stay low.
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            drive(k, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1);
        end
        #3;
        check("rst_ctrl_a", 32'(ctrl(0)), 32'(C_0));
        check("rst_ctrl_b", 32'(ctrl(1)), 32'(C_0));
        check("rst_stall_a", stall_a, 32'd0);
        check("rst_flush_a", 32'(flush_a), 32'd0);
        check("rst_state_a", 32'(st_dbg[0]), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b1;
            idle(k);
        end

        // Load-use on rs, then bubble in EX clears it.
        @(negedge clk); drive(0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0); #1;
        check("lu_rs", 32'(ctrl(0)), 32'(C_LU));
        @(negedge clk); idle(0); #1;
        check("lu_after", 32'(ctrl(0)), 32'(C_0));
        check("lu_stall_cnt", stall_a, 32'd1);
        @(negedge clk); drive(0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); #1;
        check("lu_r0", 32'(ctrl(0)), 32'(C_0));
        @(negedge clk); drive(0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0); #1;
        check("lu_rt", 32'(ctrl(0)), 32'(C_LU));
        @(negedge clk); drive(0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); #1;
        check("lu_unused", 32'(ctrl(0)), 32'(C_0));
        check("lu_stall_cnt2", stall_a, 32'd2);
        @(negedge clk); drive(0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); #1;
        check("lu_norw", 32'(ctrl(0)), 32'(C_0));

        // Redirect beats a simultaneous load-use.
        @(negedge clk); drive(0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1); #1;
        check("redir_lu", 32'(ctrl(0)), 32'(C_RD));
        @(negedge clk); idle(0); #1;
        check("redir_flush_cnt", 32'(flush_a), 32'd1);
        check("redir_stall_cnt", stall_a, 32'd2);
        check("redir_after", 32'(ctrl(0)), 32'(C_0));

        // MD_LAT=4 window; a redirect mid-window is ignored.
        @(negedge clk); drive(0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        check("md_issue", 32'(ctrl(0)), 32'(C_0));
        @(negedge clk); idle(0); #1;
        check("md_busy1", 32'(ctrl(0)), 32'(C_MD));
        check("md_state", 32'(st_dbg[0]), 32'd1);
        @(negedge clk); drive(0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); #1;
        check("md_busy2_redir", 32'(ctrl(0)), 32'(C_MD));
        @(negedge clk); idle(0); #1;
        check("md_busy3", 32'(ctrl(0)), 32'(C_MD));
        @(negedge clk); #1;
        check("md_busy4_done", 32'(ctrl(0)), 32'(C_MDD));
        @(negedge clk); #1;
        check("md_back_run", 32'(ctrl(0)), 32'(C_0));
        check("md_state_run", 32'(st_dbg[0]), 32'd0);
        check("md_stall_cnt", stall_a, 32'd6);
        check("md_flush_cnt", 32'(flush_a), 32'd1);

        // Asynchronous reset in the second busy cycle.
        @(negedge clk); drive(0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); idle(0); #1;
        check("ar_busy1", 32'(ctrl(0)), 32'(C_MD));
        @(negedge clk); #1;
        check("ar_busy2", 32'(ctrl(0)), 32'(C_MD));
        #1; rst_n[0] = 1'b0; #1;
        check("ar_ctrl", 32'(ctrl(0)), 32'(C_0));
        check("ar_stall_cnt", stall_a, 32'd0);
        check("ar_flush_cnt", 32'(flush_a), 32'd0);
        check("ar_state", 32'(st_dbg[0]), 32'd0);
        drive(0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1); #1;
        check("ar_forced", 32'(ctrl(0)), 32'(C_0));
        @(negedge clk); rst_n[0] = 1'b1; idle(0); #1;
        check("ar_release", 32'(ctrl(0)), 32'(C_0));
        @(negedge clk); #1;
        check("ar_run", 32'(ctrl(0)), 32'(C_0));
        check("ar_run_state", 32'(st_dbg[0]), 32'd0);

        // flush_count saturation.
        @(negedge clk); drive(0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); #1;
        check("sat_redir", 32'(ctrl(0)), 32'(C_RD));
        repeat (65534) @(posedge clk);
        #1;
        check("sat_flush_fffe", 32'(flush_a), 32'h0000FFFE);
        repeat (4) @(posedge clk);
        #1;
        check("sat_flush_ffff", 32'(flush_a), 32'h0000FFFF);
        check("sat_stall_zero", stall_a, 32'd0);
        @(negedge clk); idle(0);

        // Back-to-back md on instance 1 (MD_LAT=3), ID_md held high.
        @(negedge clk); drive(1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        check("b2b_issue", 32'(ctrl(1)), 32'(C_0));
        @(negedge clk); #1; check("b2b_w1c1", 32'(ctrl(1)), 32'(C_MD));
        @(negedge clk); #1; check("b2b_w1c2", 32'(ctrl(1)), 32'(C_MD));
        @(negedge clk); #1; check("b2b_w1c3", 32'(ctrl(1)), 32'(C_MDD));
        @(negedge clk); #1; check("b2b_free", 32'(ctrl(1)), 32'(C_0));
        @(negedge clk); #1; check("b2b_w2c1", 32'(ctrl(1)), 32'(C_MD));
        @(negedge clk); #1; check("b2b_w2c2", 32'(ctrl(1)), 32'(C_MD));
        @(negedge clk); idle(1); #1; check("b2b_w2c3", 32'(ctrl(1)), 32'(C_MDD));
        @(negedge clk); #1;
        check("b2b_end", 32'(ctrl(1)), 32'(C_0));
        check("b2b_stall_cnt", 32'(stall_b), 32'd6);

        // stall_cycles saturation at 4'hF.
        @(negedge clk); drive(1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); #1;
        check("sat_lu", 32'(ctrl(1)), 32'(C_LU));
        repeat (8) @(posedge clk);
        #1; check("sat_stall_e", 32'(stall_b), 32'hE);
        @(posedge clk);
        #1; check("sat_stall_f", 32'(stall_b), 32'hF);
        repeat (3) @(posedge clk);
        #1; check("sat_stall_hold", 32'(stall_b), 32'hF);
        check("sat_b_flush", 32'(flush_b), 32'd0);
        @(negedge clk); idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
